// File: rtl/serial_ripple_subtractor32.sv
// Digit-serial subtractor: result = {carry_out, A - B}, evaluated CHUNK bits per clock as A + ~B + 1.
// Optional macro APPROX_LSB_EN replaces the low APPROX_BITS with A ^ B and forces a carry into the upper part.
module serial_ripple_subtractor32 #(
  parameter int WIDTH       = 32,
  parameter int CHUNK       = 8,
  parameter int APPROX_BITS = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] minuend_i,
  input  logic [WIDTH-1:0] subtrahend_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH:0]   result_o
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int AN = APPROX_BITS / CHUNK;
`ifdef APPROX_LSB_EN
  localparam bit APPROX_ON = 1'b1;
`else
  localparam bit APPROX_ON = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] nb_q, nb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [WIDTH:0]   result_q, result_d;

  logic [CHUNK-1:0] a_chunk, nb_chunk;
  logic [CHUNK:0]   sum;
  logic             approx_chunk;
  logic             accept;

  assign ready_o  = (state_q != RUN);
  assign valid_o  = (state_q == DONE);
  assign result_o = result_q;
  assign accept   = ready_o && start_i;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    carry_d      = carry_q;
    a_d          = a_q;
    nb_d         = nb_q;
    diff_d       = diff_q;
    result_d     = result_q;
    a_chunk      = a_q[int'(cnt_q)*CHUNK +: CHUNK];
    nb_chunk     = nb_q[int'(cnt_q)*CHUNK +: CHUNK];
    approx_chunk = APPROX_ON && (cnt_q < CW'(AN));
    sum          = {1'b0, a_chunk} + {1'b0, nb_chunk} + {{CHUNK{1'b0}}, carry_q};
    // Approximate chunks: XOR difference (nb holds ~B) and a forced carry upward.
    if (approx_chunk) begin
      sum = {1'b1, a_chunk ^ ~nb_chunk};
    end

    case (state_q)
      RUN: begin
        diff_d[int'(cnt_q)*CHUNK +: CHUNK] = sum[CHUNK-1:0];
        carry_d = sum[CHUNK];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          result_d = {sum[CHUNK], diff_d};
          cnt_d    = '0;
          state_d  = DONE;
        end
      end
      default: begin
        if (accept) begin
          a_d     = minuend_i;
          nb_d    = ~subtrahend_i;
          cnt_d   = '0;
          carry_d = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b1;
      a_q      <= '0;
      nb_q     <= '0;
      diff_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      nb_q     <= nb_d;
      diff_q   <= diff_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_serial_ripple_subtractor32.sv
// Directed bench for serial_ripple_subtractor32 with hand-computed expected results.
module tb_serial_ripple_subtractor32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a, b;
  logic        ready, valid;
  logic [32:0] result;

  int checks = 0;
  int errors = 0;
  int lat;
  int pulses;

  serial_ripple_subtractor32 dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .minuend_i   (a),
    .subtrahend_i(b),
    .ready_o     (ready),
    .valid_o     (valid),
    .result_o    (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present operands with start for one cycle; returns at the negedge after the accepting edge.
  task automatic issue(input logic [31:0] av, input logic [31:0] bv);
    a     = av;
    b     = bv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 1;
    while (!valid && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic count_pulses(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (valid) n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic [32:0] exp);
    check({tag, "_ready_before"}, {32'b0, ready}, 33'd1);
    issue(av, bv);
    check({tag, "_ready_busy"}, {32'b0, ready}, 33'd0);
    wait_valid(lat);
    check({tag, "_latency"}, 33'(lat), 33'd5);
    check({tag, "_result"}, result, exp);
    @(negedge clk);
    check({tag, "_valid_drop"}, {32'b0, valid}, 33'd0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_ready", {32'b0, ready}, 33'd1);
    check("reset_valid", {32'b0, valid}, 33'd0);
    check("reset_result", result, 33'h0_0000_0000);

    run_op("a5_b3",        32'h0000_0005, 32'h0000_0003, 33'h1_0000_0002);
    run_op("a3_b5",        32'h0000_0003, 32'h0000_0005, 33'h0_FFFF_FFFE);
    run_op("borrow_chain", 32'h8000_0000, 32'h0000_0001, 33'h1_7FFF_FFFF);
    run_op("a_eq_b",       32'hDEAD_BEEF, 32'hDEAD_BEEF, 33'h1_0000_0000);
    run_op("zero_minus_1s",32'h0000_0000, 32'hFFFF_FFFF, 33'h0_0000_0001);
    run_op("zero_zero",    32'h0000_0000, 32'h0000_0000, 33'h1_0000_0000);

    // Start pulse and operand change during RUN must not disturb the operation.
    issue(32'h0000_000A, 32'h0000_0004);
    @(negedge clk);
    a     = 32'h1234_5678;
    b     = 32'h0000_0001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 3;
    while (!valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("ignore_latency", 33'(lat), 33'd5);
    check("ignore_result", result, 33'h1_0000_0006);
    count_pulses(12, pulses);
    check("ignore_single_valid", 33'(pulses), 33'd0);

    // Back-to-back: second start in the DONE cycle.
    issue(32'h0000_0007, 32'h0000_0002);
    wait_valid(lat);
    check("b2b_first_latency", 33'(lat), 33'd5);
    check("b2b_first_result", result, 33'h1_0000_0005);
    check("b2b_done_ready", {32'b0, ready}, 33'd1);
    issue(32'h0000_0002, 32'h0000_0007);
    check("b2b_second_busy", {32'b0, ready}, 33'd0);
    wait_valid(lat);
    check("b2b_second_gap", 33'(lat), 33'd5);
    check("b2b_second_result", result, 33'h0_FFFF_FFFB);
    @(negedge clk);

    // Reset in the second RUN cycle aborts silently.
    issue(32'h0000_0009, 32'h0000_0001);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready", {32'b0, ready}, 33'd1);
    check("abort_valid", {32'b0, valid}, 33'd0);
    check("abort_result", result, 33'h0_0000_0000);
    count_pulses(10, pulses);
    check("abort_no_valid", 33'(pulses), 33'd0);

`ifdef APPROX_LSB_EN
    run_op("approx_100_1", 32'h0000_0100, 32'h0000_0001, 33'h1_0000_0101);
    run_op("approx_105_3", 32'h0000_0105, 32'h0000_0003, 33'h1_0000_0106);
`else
    run_op("exact_100_1",  32'h0000_0100, 32'h0000_0001, 33'h1_0000_00FF);
    run_op("exact_105_3",  32'h0000_0105, 32'h0000_0003, 33'h1_0000_0102);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_ripple_subtractor32.md
Name: serial_ripple_subtractor32

Overview:
- Multi-cycle, digit-serial ripple-borrow subtractor: result_o = minuend_i - subtrahend_i.
- Computed as minuend + ~subtrahend + 1, CHUNK bits per clock.
- Result uses the same {carry, sum} format as the team's combinational adders, so it drops into the same datapaths.
- Trades latency for a short carry chain; handshake is start/ready/valid.

Parameters:
- WIDTH, 32, operand width in bits.
- CHUNK, 8, bits processed per cycle. WIDTH must be a multiple of CHUNK. N = WIDTH/CHUNK.
- APPROX_BITS, 8, number of LSBs approximated when APPROX_LSB_EN is defined. Must be a multiple of CHUNK and less than WIDTH.

Ports:
- clk_i  input  1  clock; all logic on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- start_i  input  1  request; sampled only while ready_o=1.
- minuend_i  input  WIDTH  operand A; captured on the accepted start.
- subtrahend_i  input  WIDTH  operand B; captured on the accepted start.
- ready_o  output  1  block can accept start_i.
- valid_o  output  1  one-cycle pulse; result_o is valid.
- result_o  output  WIDTH+1  {carry_out, difference}. carry_out=1 iff A>=B (unsigned).

Behaviour:
- Reset (rst_i=1 at an edge):
  - state=IDLE, ready_o=1, valid_o=0, result_o=0.
  - Chunk counter=0, internal carry=1.
  - Reset wins over any other event in the same cycle. Reset mid-RUN aborts silently; no valid_o is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - ready_o=1, valid_o=0.
  - start_i=1 -> capture A, ~B; counter=0; carry=1; go to RUN.
- RUN:
  - ready_o=0, valid_o=0.
  - Each edge processes chunk k = bits [k*CHUNK +: CHUNK]: {c, s} = A_k + ~B_k + carry. s is written to the difference register; carry <= c; counter++.
  - After chunk N-1 is processed, carry_out is loaded into result_o[WIDTH] and the state goes to DONE.
  - start_i is ignored while in RUN.
- DONE:
  - valid_o=1 for exactly this cycle; ready_o=1.
  - start_i=1 -> accept new operands, go to RUN (back-to-back operation).
  - Otherwise go to IDLE.
- Latency: start sampled at edge E -> valid_o high in the cycle following edge E+N (N=4 at defaults). Throughput is one result per N+1 cycles.
- result_o:
  - Updated only when the final chunk completes.
  - Holds its value until the next completion or reset. Intermediate chunks go to an internal register, not to result_o.
- Operands are captured at accept; input changes afterwards do not affect the operation in flight.
- Arithmetic is unsigned modulo 2^WIDTH. Two's-complement signed use reads result_o[WIDTH-1:0] only.
- Boundary values:
  - A=B gives {1, 0}.
  - A=0, B=0 gives {1, 0}.
  - A=0, B=all-ones gives {0, 1}.

Optional Feature:
- Macro: APPROX_LSB_EN.
- Defined:
  - Low APPROX_BITS of the difference = A ^ B, with no borrow propagation.
  - Carry into bit APPROX_BITS is forced to 1.
  - Chunks below APPROX_BITS are still clocked, so latency is unchanged.
  - carry_out is computed from the upper part only.
- Undefined: exact subtraction; the APPROX_BITS parameter has no effect.

Test Plan:
- A=0x00000005, B=0x00000003, start 1 cycle -> ready_o low 4 cycles; valid_o pulse after edge E+4; result_o=0x1_00000002.
- A=0x00000003, B=0x00000005 -> result_o=0x0_FFFFFFFE. A=0x80000000, B=0x00000001 -> result_o=0x1_7FFFFFFF (borrow ripples across all chunks).
- A=B=0xDEADBEEF -> result_o=0x1_00000000. A=0, B=0xFFFFFFFF -> result_o=0x0_00000001.
- Pulse start_i again during RUN with other operands -> ignored; first result correct; exactly one valid_o.
- Assert start_i in the DONE cycle -> second operation accepted with no IDLE gap; its valid_o arrives 5 cycles after the first.
- Assert rst_i at the 2nd RUN cycle -> ready_o=1, valid_o=0, result_o=0 next cycle; no valid_o pulse afterwards.
- APPROX_LSB_EN defined, A=0x00000100, B=0x00000001 -> result_o=0x1_00000101 (exact would be 0x1_000000FF). A=0x00000105, B=0x00000003 -> result_o=0x1_00000106.
